// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// A bubble (flush from EX or load-use stall) clears the EX slot to an all-zero NOP.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write_d,
  input  logic        mem_write_d,
  input  logic        slt_d,
  input  logic        lui_d,
  input  logic        alu_src_d,
  input  logic [1:0]  result_src_d,
  input  logic [2:0]  ex_d,
  input  logic [1:0]  jump_t_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] pc_plus4_d,
  input  logic [31:0] rd1_d,
  input  logic [31:0] rd2_d,
  input  logic [31:0] imm_d,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_d,
  input  logic        valid_d,
  input  logic        flush_e,
  output logic        reg_write_e,
  output logic        mem_write_e,
  output logic        slt_e,
  output logic        lui_e,
  output logic        alu_src_e,
  output logic [1:0]  result_src_e,
  output logic [2:0]  ex_e,
  output logic [1:0]  jump_t_e,
  output logic [31:0] pc_e,
  output logic [31:0] pc_plus4_e,
  output logic [31:0] rd1_e,
  output logic [31:0] rd2_e,
  output logic [31:0] imm_e,
  output logic [4:0]  rs1_e,
  output logic [4:0]  rs2_e,
  output logic [4:0]  rd_e,
  output logic        valid_e,
  output logic        lw_stall,
  output logic        stall_f,
  output logic        stall_d,
  output logic [15:0] bubble_cnt
);

  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_write;
    logic        slt;
    logic        lui;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  ex;
    logic [1:0]  jump_t;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } ex_slot_t;

  ex_slot_t    slot_in;
  ex_slot_t    slot_d, slot_q;
  logic [15:0] bubble_cnt_d, bubble_cnt_q;
  logic        bubble;

  assign slot_in = '{
    valid:      valid_d,
    reg_write:  reg_write_d,
    mem_write:  mem_write_d,
    slt:        slt_d,
    lui:        lui_d,
    alu_src:    alu_src_d,
    result_src: result_src_d,
    ex:         ex_d,
    jump_t:     jump_t_d,
    pc:         pc_d,
    pc_plus4:   pc_plus4_d,
    rd1:        rd1_d,
    rd2:        rd2_d,
    imm:        imm_d,
    rs1:        rs1_d,
    rs2:        rs2_d,
    rd:         rd_d
  };

  // x0 is hardwired zero, so a load targeting it can never create a hazard.
  assign lw_stall = slot_q.valid && valid_d && (slot_q.result_src == RES_LOAD) &&
                    (slot_q.rd != 5'd0) && ((rs1_d == slot_q.rd) || (rs2_d == slot_q.rd));
  assign stall_f  = lw_stall;
  assign stall_d  = lw_stall;
  assign bubble   = flush_e || lw_stall;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    slot_d       = slot_in;
    bubble_cnt_d = bubble_cnt_q;
    if (bubble) begin
      slot_d = '0;
      if (bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      slot_q       <= slot_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_e      = slot_q.valid;
  assign reg_write_e  = slot_q.reg_write;
  assign mem_write_e  = slot_q.mem_write;
  assign slt_e        = slot_q.slt;
  assign lui_e        = slot_q.lui;
  assign alu_src_e    = slot_q.alu_src;
  assign result_src_e = slot_q.result_src;
  assign ex_e         = slot_q.ex;
  assign jump_t_e     = slot_q.jump_t;
  assign pc_e         = slot_q.pc;
  assign pc_plus4_e   = slot_q.pc_plus4;
  assign rd1_e        = slot_q.rd1;
  assign rd2_e        = slot_q.rd2;
  assign imm_e        = slot_q.imm;
  assign rs1_e        = slot_q.rs1;
  assign rs2_e        = slot_q.rs2;
  assign rd_e         = slot_q.rd;
  assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage against a record-level reference model.
// Directed cases cover pass-through, load-use, x0, flush, reset priority and counter saturation.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_write;
    logic        slt;
    logic        lui;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  ex;
    logic [1:0]  jump_t;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_e = 1'b0;
  rec_t        din = '0;
  rec_t        dout;

  logic        reg_write_e, mem_write_e, slt_e, lui_e, alu_src_e, valid_e;
  logic [1:0]  result_src_e, jump_t_e;
  logic [2:0]  ex_e;
  logic [31:0] pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        lw_stall, stall_f, stall_d;
  logic [15:0] bubble_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  rec_t        m = '0;
  int unsigned m_cnt = 0;
  bit          m_known = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .reg_write_d(din.reg_write), .mem_write_d(din.mem_write), .slt_d(din.slt),
    .lui_d(din.lui), .alu_src_d(din.alu_src), .result_src_d(din.result_src),
    .ex_d(din.ex), .jump_t_d(din.jump_t), .pc_d(din.pc), .pc_plus4_d(din.pc_plus4),
    .rd1_d(din.rd1), .rd2_d(din.rd2), .imm_d(din.imm), .rs1_d(din.rs1),
    .rs2_d(din.rs2), .rd_d(din.rd), .valid_d(din.valid), .flush_e(flush_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .slt_e(slt_e), .lui_e(lui_e),
    .alu_src_e(alu_src_e), .result_src_e(result_src_e), .ex_e(ex_e), .jump_t_e(jump_t_e),
    .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .valid_e(valid_e),
    .lw_stall(lw_stall), .stall_f(stall_f), .stall_d(stall_d), .bubble_cnt(bubble_cnt)
  );

  assign dout = {valid_e, reg_write_e, mem_write_e, slt_e, lui_e, alu_src_e, result_src_e,
                 ex_e, jump_t_e, pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit hazard(input rec_t ex_slot, input rec_t id);
    return ex_slot.valid && id.valid && ex_slot.result_src == 2'b01 && ex_slot.rd != 0 &&
           (id.rs1 == ex_slot.rd || id.rs2 == ex_slot.rd);
  endfunction

  // One clock: apply ID inputs, check the combinational stall, advance the model, check EX regs.
  task automatic cycle(input rec_t d, input logic r, input logic f);
    bit exp_stall;
    @(negedge clk);
    din = d; rst = r; flush_e = f;
    #1;
    exp_stall = m_known && hazard(m, d);
    if (m_known) begin
      check("lw_stall", 256'(lw_stall), 256'(exp_stall));
      check("stall_f",  256'(stall_f),  256'(exp_stall));
      check("stall_d",  256'(stall_d),  256'(exp_stall));
    end
    @(posedge clk);
    if (r) begin
      m = '0; m_cnt = 0; m_known = 1'b1;
    end else if (f || exp_stall) begin
      m = '0; m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    end else begin
      m = d;
    end
    #1;
    check("ex_regs",    256'(dout),       256'(m));
    check("bubble_cnt", 256'(bubble_cnt), 256'(m_cnt));
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r = rec_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    r.valid = ($urandom_range(0, 7) != 0);
    r.rs1   = 5'($urandom_range(0, 3));
    r.rs2   = 5'($urandom_range(0, 3));
    r.rd    = 5'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    rec_t d, ld;

    cycle('0, 1'b1, 1'b0);
    cycle('0, 1'b1, 1'b0);
    check("reset_lw_stall", 256'(lw_stall), 256'(0));

    // Pass-through of a plain instruction.
    d = '0; d.valid = 1; d.ex = 3'b101; d.jump_t = 2'b11; d.rd1 = 32'h1234_5678;
    cycle(d, 1'b0, 1'b0);
    check("pt_ex",     256'(ex_e),     256'(3'b101));
    check("pt_jump_t", 256'(jump_t_e), 256'(2'b11));
    check("pt_rd1",    256'(rd1_e),    256'(32'h1234_5678));
    check("pt_valid",  256'(valid_e),  256'(1));
    check("pt_stall",  256'(lw_stall), 256'(0));

    // Load-use on rs2 inserts exactly one bubble.
    ld = '0; ld.valid = 1; ld.result_src = 2'b01; ld.rd = 5'd5; ld.ex = 3'b010;
    cycle(ld, 1'b0, 1'b0);
    d = '0; d.valid = 1; d.rs2 = 5'd5; d.ex = 3'b110;
    check("lu_stall_pre", 256'(lw_stall), 256'(0));
    cycle(d, 1'b0, 1'b0);
    check("lu_valid",  256'(valid_e),    256'(0));
    check("lu_ex",     256'(ex_e),       256'(0));
    check("lu_cnt",    256'(bubble_cnt), 256'(1));
    check("lu_release", 256'(lw_stall),  256'(0));
    cycle(d, 1'b0, 1'b0);
    check("lu_reissue", 256'(ex_e), 256'(3'b110));

    // A load to x0 never stalls.
    ld.rd = 5'd0;
    cycle(ld, 1'b0, 1'b0);
    d = '0; d.valid = 1; d.rs1 = 5'd0; d.imm = 32'hCAFE_0000;
    cycle(d, 1'b0, 1'b0);
    check("x0_imm", 256'(imm_e),      256'(32'hCAFE_0000));
    check("x0_cnt", 256'(bubble_cnt), 256'(1));

    // Flush kills a writing instruction; flush with stall counts once.
    d = '0; d.valid = 1; d.reg_write = 1; d.mem_write = 1; d.jump_t = 2'b10;
    cycle(d, 1'b0, 1'b1);
    check("fl_valid", 256'({valid_e, reg_write_e, mem_write_e, jump_t_e}), 256'(0));
    check("fl_cnt",   256'(bubble_cnt), 256'(2));
    ld.rd = 5'd7;
    cycle(ld, 1'b0, 1'b0);
    d = '0; d.valid = 1; d.rs1 = 5'd7;
    cycle(d, 1'b0, 1'b1);
    check("fl_stall_cnt", 256'(bubble_cnt), 256'(3));

    // valid_d=0 loads the fields but does not count as a bubble.
    d = '0; d.valid = 0; d.pc = 32'h0000_1000; d.rd = 5'd9;
    cycle(d, 1'b0, 1'b0);
    check("nv_pc",  256'(pc_e),       256'(32'h0000_1000));
    check("nv_cnt", 256'(bubble_cnt), 256'(3));

    // Reset beats a simultaneous flush and load-use stall.
    ld.rd = 5'd5;
    cycle(ld, 1'b0, 1'b0);
    d = '0; d.valid = 1; d.rs1 = 5'd5; d.rd1 = 32'hFFFF_FFFF;
    cycle(d, 1'b1, 1'b1);
    check("rp_regs", 256'(dout),       256'(0));
    check("rp_cnt",  256'(bubble_cnt), 256'(0));
    cycle(d, 1'b0, 1'b0);
    check("rp_reload", 256'(rd1_e), 256'(32'hFFFF_FFFF));

    // Random traffic with hazards, flushes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      d = rand_rec();
      if ($urandom_range(0, 3) == 0) d.result_src = 2'b01;
      cycle(d, ($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0));
    end

    // Saturation: hold flush to reach 65534, then three more bubbles.
    cycle('0, 1'b1, 1'b0);
    @(negedge clk);
    flush_e = 1'b1; din = '0; rst = 1'b0;
    for (int i = 0; i < 65533; i++) begin
      @(posedge clk);
      m_cnt++;
    end
    @(negedge clk);
    check("sat_pre", 256'(bubble_cnt), 256'(65533));
    for (int i = 0; i < 1; i++) begin
      @(posedge clk);
      m_cnt++;
    end
    #1;
    check("sat_65534", 256'(bubble_cnt), 256'(16'hFFFE));
    for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b1);
    check("sat_hold", 256'(bubble_cnt), 256'(16'hFFFF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 reg_write_d, mem_write_d, slt_d, lui_d, alu_src_d  input  1 each  ID-stage control bits.
REQ-004 result_src_d  input  2  writeback select (2'b01 = load from memory).
REQ-005 ex_d  input  3  ALU/EX operation code for the EX control decoder.
REQ-006 jump_t_d  input  2  00 none, 01 JAL, 10 JALR, 11 BRANCH.
REQ-007 pc_d, pc_plus4_d, rd1_d, rd2_d, imm_d  input  32 each  ID-stage datapath values.
REQ-008 rs1_d, rs2_d, rd_d  input  5 each  register indices.
REQ-009 valid_d  input  1  ID slot holds a real instruction.
REQ-010 flush_e  input  1  taken branch/jump resolved in EX; kill the instruction entering EX.
REQ-011 Each *_d field in REQ-003 to REQ-009 has a registered *_e output of equal width.
REQ-012 lw_stall  output  1  combinational load-use hazard indication.
REQ-013 stall_f, stall_d  output  1 each  hold IF PC and IF/ID register; equal to lw_stall.
REQ-014 bubble_cnt  output  16  saturating count of bubbles inserted.

Function
REQ-015 lw_stall SHALL be 1 iff valid_e & valid_d & (result_src_e==2'b01) & (rd_e!=0) & ((rs1_d==rd_e) | (rs2_d==rd_e)).
REQ-016 Per-edge priority SHALL be: rst > flush_e > lw_stall > load.
REQ-017 Load (no rst, flush_e=0, lw_stall=0): every *_e SHALL take its *_d value next cycle; latency 1 cycle.
REQ-018 Bubble (flush_e=1 or lw_stall=1): valid_e, reg_write_e, mem_write_e, slt_e, lui_e, alu_src_e SHALL clear to 0; result_src_e=00; ex_e=000; jump_t_e=00; all 32-bit and 5-bit fields SHALL clear to 0.
REQ-019 A bubble SHALL increment bubble_cnt by 1; at 16'hFFFF it SHALL hold.
REQ-020 flush_e and lw_stall both high: one bubble, one increment.
REQ-021 valid_d=0 with no flush/stall: fields SHALL load as given; valid_e=0, and bubble_cnt SHALL NOT increment.
REQ-022 lw_stall SHALL depend only on current *_e registers and ID inputs (no added latency); it SHALL last exactly one cycle per hazard, because the bubble clears valid_e.
REQ-023 rd_e=0 SHALL never raise lw_stall (x0 never hazards).
REQ-024 No internal state besides the *_e registers and bubble_cnt.

Reset
REQ-025 rst=1 at an edge SHALL zero every *_e output and bubble_cnt, overriding flush_e and lw_stall.
REQ-026 During rst, lw_stall/stall_f/stall_d SHALL evaluate from current registers; after the first reset edge they SHALL be 0.
REQ-027 Reset mid-stall SHALL leave no pending bubble; the first post-reset edge with clean inputs SHALL load normally.

Verification
REQ-028 Pass-through: ex_d=3'b101, jump_t_d=11, rd1_d=32'h1234_5678, valid_d=1 -> next cycle ex_e=101, jump_t_e=11, rd1_e=32'h1234_5678, valid_e=1, lw_stall=0.
REQ-029 Load-use: EX holds load (result_src_e=01, rd_e=5, valid_e=1); ID rs2_d=5 -> lw_stall=stall_f=stall_d=1; next cycle valid_e=0, ex_e=000, bubble_cnt +1, lw_stall=0.
REQ-030 x0 load: result_src_e=01, rd_e=0, rs1_d=0 -> lw_stall=0, normal load.
REQ-031 Flush: flush_e=1 with valid_d=1, reg_write_d=1, mem_write_d=1 -> next cycle valid_e=0, reg_write_e=0, mem_write_e=0, jump_t_e=00; flush_e and lw_stall together -> bubble_cnt +1 only.
REQ-032 Saturation: preload 65534 bubbles, apply 3 more -> bubble_cnt=16'hFFFF held.
REQ-033 Reset priority: rst=1 with flush_e=1 and lw_stall=1 -> all outputs 0, bubble_cnt=0 next cycle.
